// File: rtl/ttt_move_controller.sv
// ttt_move_controller: sequences a 3x3 tic-tac-toe game on top of cell_module.
// Validates raw move requests against an internal board mirror, issues a
// select pulse of SELECT_CYCLES clocks per legal move, alternates players,
// and detects a win or a draw before halting until a new game is requested.
module ttt_move_controller #(
    parameter int FIRST_PLAYER  = 0,
    parameter int SELECT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        move_req,
    input  logic [1:0]  row_in,
    input  logic [1:0]  col_in,
    input  logic        new_game,
    output logic        player,
    output logic        select,
    output logic [1:0]  row,
    output logic [1:0]  col,
    output logic        cell_clear,
    output logic [17:0] board,
    output logic [3:0]  move_count,
    output logic        illegal_move,
    output logic        game_over,
    output logic [1:0]  winner
);

    typedef enum logic [2:0] {
        S_PLAY   = 3'd0,
        S_CHECK  = 3'd1,
        S_COMMIT = 3'd2,
        S_EVAL   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic       FIRST_P     = 1'(FIRST_PLAYER);
    localparam logic [1:0] SEL_CNT_TOP = 2'(SELECT_CYCLES - 1);

    state_t      state_q;
    logic        player_q;
    logic        select_q;
    logic [1:0]  row_q;
    logic [1:0]  col_q;
    logic        cell_clear_q;
    logic [17:0] board_q;
    logic [3:0]  move_count_q;
    logic        illegal_q;
    logic        game_over_q;
    logic [1:0]  winner_q;
    logic [1:0]  sel_cnt_q;

    // Per-cell view of the packed board mirror.
    logic [1:0] cell_w [9];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_cells
            assign cell_w[gi] = board_q[2*gi+1 : 2*gi];
        end
    endgenerate

    // Line checks: entries 0..2 are rows, 3..5 columns, 6..7 diagonals.
    logic [1:0] line_code [8];
    logic [7:0] line_win;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_lines
            assign line_code[gi]   = cell_w[3*gi];
            assign line_win[gi]    = (cell_w[3*gi] != 2'b00)
                                   && (cell_w[3*gi] == cell_w[3*gi+1])
                                   && (cell_w[3*gi] == cell_w[3*gi+2]);
            assign line_code[3+gi] = cell_w[gi];
            assign line_win[3+gi]  = (cell_w[gi] != 2'b00)
                                   && (cell_w[gi] == cell_w[gi+3])
                                   && (cell_w[gi] == cell_w[gi+6]);
        end
    endgenerate

    assign line_code[6] = cell_w[0];
    assign line_win[6]  = (cell_w[0] != 2'b00) && (cell_w[0] == cell_w[4])
                        && (cell_w[0] == cell_w[8]);
    assign line_code[7] = cell_w[2];
    assign line_win[7]  = (cell_w[2] != 2'b00) && (cell_w[2] == cell_w[4])
                        && (cell_w[2] == cell_w[6]);

    // Winning code of any completed line; 00 when no line is complete.
    logic [1:0] win_code_d;
    always_comb begin
        win_code_d = 2'b00;
        for (int l = 0; l < 8; l++) begin
            if (line_win[l]) begin
                win_code_d = line_code[l];
            end
        end
    end

    // Legality of the latched request: off-board coordinate or occupied cell.
    logic [3:0] cell_idx_d;
    logic       target_busy_d;
    logic       move_illegal_d;
    always_comb begin
        cell_idx_d    = ({2'b00, row_q} * 4'd3) + {2'b00, col_q};
        target_busy_d = 1'b0;
        if ((row_q != 2'd3) && (col_q != 2'd3)) begin
            target_busy_d = (cell_w[cell_idx_d] != 2'b00);
        end
        move_illegal_d = (row_q == 2'd3) || (col_q == 2'd3) || target_busy_d;
    end

    // Game sequencer with registered outputs; new_game overrides any state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_PLAY;
            player_q     <= FIRST_P;
            select_q     <= 1'b0;
            row_q        <= 2'd0;
            col_q        <= 2'd0;
            cell_clear_q <= 1'b0;
            board_q      <= 18'd0;
            move_count_q <= 4'd0;
            illegal_q    <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 2'b00;
            sel_cnt_q    <= 2'd0;
        end else if (new_game) begin
            state_q      <= S_PLAY;
            player_q     <= FIRST_P;
            select_q     <= 1'b0;
            cell_clear_q <= 1'b1;
            board_q      <= 18'd0;
            move_count_q <= 4'd0;
            illegal_q    <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 2'b00;
            sel_cnt_q    <= 2'd0;
        end else begin
            cell_clear_q <= 1'b0;
            illegal_q    <= 1'b0;
            case (state_q)
                S_PLAY: begin
                    if (move_req) begin
                        row_q   <= row_in;
                        col_q   <= col_in;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (move_illegal_d) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_PLAY;
                    end else begin
                        select_q     <= 1'b1;
                        sel_cnt_q    <= SEL_CNT_TOP;
                        move_count_q <= move_count_q + 4'd1;
                        for (int k = 0; k < 9; k++) begin
                            if (cell_idx_d == 4'(k)) begin
                                board_q[2*k +: 2] <= player_q ? 2'b10 : 2'b01;
                            end
                        end
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (sel_cnt_q == 2'd0) begin
                        select_q <= 1'b0;
                        state_q  <= S_EVAL;
                    end else begin
                        sel_cnt_q <= sel_cnt_q - 2'd1;
                    end
                end
                S_EVAL: begin
                    if (win_code_d != 2'b00) begin
                        winner_q    <= win_code_d;
                        game_over_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (move_count_q == 4'd9) begin
                        winner_q    <= 2'b11;
                        game_over_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        player_q <= ~player_q;
                        state_q  <= S_PLAY;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_PLAY;
                end
            endcase
        end
    end

    assign player       = player_q;
    assign select       = select_q;
    assign row          = row_q;
    assign col          = col_q;
    assign cell_clear   = cell_clear_q;
    assign board        = board_q;
    assign move_count   = move_count_q;
    assign illegal_move = illegal_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_ttt_move_controller.sv
// Testbench for ttt_move_controller: two instances (SELECT_CYCLES=1 with
// FIRST_PLAYER=0, SELECT_CYCLES=3 with FIRST_PLAYER=1) share one stimulus
// stream and are checked every cycle against a timeline model of the game.
module tb_ttt_move_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       move_req = 1'b0;
    logic [1:0] row_in = 2'd0;
    logic [1:0] col_in = 2'd0;
    logic       new_game = 1'b0;

    logic        d_player [2];
    logic        d_select [2];
    logic [1:0]  d_row    [2];
    logic [1:0]  d_col    [2];
    logic        d_clr    [2];
    logic [17:0] d_board  [2];
    logic [3:0]  d_cnt    [2];
    logic        d_ill    [2];
    logic        d_go     [2];
    logic [1:0]  d_win    [2];

    always #5 clock = ~clock;

    ttt_move_controller #(.FIRST_PLAYER(0), .SELECT_CYCLES(1)) u_dut0 (
        .clock(clock), .reset(reset), .move_req(move_req), .row_in(row_in),
        .col_in(col_in), .new_game(new_game), .player(d_player[0]),
        .select(d_select[0]), .row(d_row[0]), .col(d_col[0]),
        .cell_clear(d_clr[0]), .board(d_board[0]), .move_count(d_cnt[0]),
        .illegal_move(d_ill[0]), .game_over(d_go[0]), .winner(d_win[0])
    );

    ttt_move_controller #(.FIRST_PLAYER(1), .SELECT_CYCLES(3)) u_dut1 (
        .clock(clock), .reset(reset), .move_req(move_req), .row_in(row_in),
        .col_in(col_in), .new_game(new_game), .player(d_player[1]),
        .select(d_select[1]), .row(d_row[1]), .col(d_col[1]),
        .cell_clear(d_clr[1]), .board(d_board[1]), .move_count(d_cnt[1]),
        .illegal_move(d_ill[1]), .game_over(d_go[1]), .winner(d_win[1])
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 60)
                $display("FAIL %s dut%0d t=%0t: got %0h expected %0h",
                         name, inst, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_t counts clocks since a request was accepted (-1 = waiting for one):
    // t=1 legality decision, select from t=1 to t=SC, t=SC+2 win/draw check.
    int m_board [2][9];
    int m_player[2], m_cnt[2], m_t[2], m_row[2], m_col[2], m_win[2];
    bit m_sel[2], m_clr[2], m_ill[2], m_go[2];

    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic int sc_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int fp_of(int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic int line_winner(int i);
        int w = 0;
        for (int l = 0; l < 8; l++) begin
            int a = m_board[i][lines[l][0]];
            if (a != 0 && a == m_board[i][lines[l][1]] && a == m_board[i][lines[l][2]])
                w = a;
        end
        return w;
    endfunction

    function automatic logic [17:0] packed_board(int i);
        logic [17:0] b = '0;
        for (int k = 0; k < 9; k++) b[2*k +: 2] = 2'(m_board[i][k]);
        return b;
    endfunction

    task automatic model_clear(int i);
        for (int k = 0; k < 9; k++) m_board[i][k] = 0;
        m_cnt[i] = 0; m_win[i] = 0; m_go[i] = 0; m_sel[i] = 0;
        m_ill[i] = 0; m_player[i] = fp_of(i); m_t[i] = -1;
    endtask

    task automatic model_step(int i);
        if (!reset) begin
            model_clear(i);
            m_row[i] = 0; m_col[i] = 0; m_clr[i] = 0;
        end else if (new_game) begin
            model_clear(i);
            m_clr[i] = 1;
        end else begin
            m_clr[i] = 0;
            m_ill[i] = 0;
            if (m_t[i] < 0) begin
                if (!m_go[i] && move_req) begin
                    m_row[i] = int'(row_in);
                    m_col[i] = int'(col_in);
                    m_t[i] = 0;
                end
            end else begin
                m_t[i]++;
                if (m_t[i] == 1) begin
                    if (m_row[i] > 2 || m_col[i] > 2 ||
                        m_board[i][m_row[i]*3 + m_col[i]] != 0) begin
                        m_ill[i] = 1;
                        m_t[i] = -1;
                    end else begin
                        m_board[i][m_row[i]*3 + m_col[i]] = m_player[i] + 1;
                        m_cnt[i]++;
                        m_sel[i] = 1;
                    end
                end else if (m_t[i] == sc_of(i) + 1) begin
                    m_sel[i] = 0;
                end else if (m_t[i] == sc_of(i) + 2) begin
                    int w = line_winner(i);
                    if (w != 0) begin
                        m_win[i] = w; m_go[i] = 1;
                    end else if (m_cnt[i] == 9) begin
                        m_win[i] = 3; m_go[i] = 1;
                    end else begin
                        m_player[i] = 1 - m_player[i];
                    end
                    m_t[i] = -1;
                end
            end
        end
    endtask

    // Advance the model on every active edge using the inputs seen there.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                cmp("player",       i, 32'(d_player[i]), 32'(m_player[i]));
                cmp("select",       i, 32'(d_select[i]), 32'(m_sel[i]));
                cmp("row",          i, 32'(d_row[i]),    32'(m_row[i]));
                cmp("col",          i, 32'(d_col[i]),    32'(m_col[i]));
                cmp("cell_clear",   i, 32'(d_clr[i]),    32'(m_clr[i]));
                cmp("board",        i, 32'(d_board[i]),  32'(packed_board(i)));
                cmp("move_count",   i, 32'(d_cnt[i]),    32'(m_cnt[i]));
                cmp("illegal_move", i, 32'(d_ill[i]),    32'(m_ill[i]));
                cmp("game_over",    i, 32'(d_go[i]),     32'(m_go[i]));
                cmp("winner",       i, 32'(d_win[i]),    32'(m_win[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clock);
    endtask

    task automatic wait_cycles(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Strobe move_req for exactly one active edge; returns just after it.
    task automatic pulse_move(int r, int c);
        move_req = 1'b1; row_in = 2'(r); col_in = 2'(c);
        step();
        move_req = 1'b0;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        wait_cycles(2);
    endtask

    task automatic play(int r, int c);
        pulse_move(r, c);
        wait_cycles(7);
    endtask

    // Count illegal pulses and selects on dut0 after one request.
    task automatic probe_illegal(int r, int c, string name);
        int ill = 0, sel = 0;
        pulse_move(r, c);
        for (int k = 0; k < 7; k++) begin
            if (d_ill[0]) ill++;
            if (d_select[0]) sel++;
            step();
        end
        cmp({name, "_illegal_pulses"}, 0, 32'(ill), 32'd1);
        cmp({name, "_selects"}, 0, 32'(sel), 32'd0);
    endtask

    int draw_r[9] = '{0,0,0,1,1,1,2,2,2};
    int draw_c[9] = '{0,1,2,1,0,2,1,0,2};

    initial begin
        // 1: reset held low for two edges
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b1;
        step();
        cmp("reset_board", 0, 32'(d_board[0]), 32'h0);
        cmp("reset_player", 0, 32'(d_player[0]), 32'd0);
        cmp("reset_player", 1, 32'(d_player[1]), 32'd1);
        $display("reset released: board0=%0h player0=%0d", d_board[0], d_player[0]);

        // 2: move (1,1), select exactly in the second cycle after the request
        pulse_move(1, 1);
        cmp("lat_sel_n1", 0, 32'(d_select[0]), 32'd0);
        step();
        cmp("lat_sel_n2", 0, 32'(d_select[0]), 32'd1);
        cmp("lat_row", 0, 32'(d_row[0]), 32'd1);
        cmp("lat_col", 0, 32'(d_col[0]), 32'd1);
        cmp("lat_player", 0, 32'(d_player[0]), 32'd0);
        step();
        cmp("lat_sel_n3", 0, 32'(d_select[0]), 32'd0);
        step();
        cmp("lat_cell11", 0, 32'(d_board[0][9:8]), 32'd1);
        cmp("lat_count", 0, 32'(d_cnt[0]), 32'd1);
        cmp("lat_player_toggled", 0, 32'(d_player[0]), 32'd1);
        wait_cycles(4);
        $display("move (1,1): board0=%05h count0=%0d", d_board[0], d_cnt[0]);

        // 3: illegal requests
        probe_illegal(1, 1, "occupied");
        probe_illegal(3, 0, "row3");
        cmp("illegal_board", 0, 32'(d_board[0]), 32'h00100);
        cmp("illegal_player", 0, 32'(d_player[0]), 32'd1);
        $display("illegal requests done: count0=%0d", d_cnt[0]);

        // 4: player0 wins on row 0
        pulse_new_game();
        play(0, 0); play(1, 0); play(0, 1); play(1, 1); play(0, 2);
        cmp("win_winner", 0, 32'(d_win[0]), 32'd1);
        cmp("win_game_over", 0, 32'(d_go[0]), 32'd1);
        cmp("win_count", 0, 32'(d_cnt[0]), 32'd5);
        cmp("win_winner_sc3", 1, 32'(d_win[1]), 32'd2);
        begin
            int sel = 0, ill = 0;
            pulse_move(2, 2);
            for (int k = 0; k < 7; k++) begin
                if (d_select[0] || d_select[1]) sel++;
                if (d_ill[0] || d_ill[1]) ill++;
                step();
            end
            cmp("done_selects", 0, 32'(sel), 32'd0);
            cmp("done_illegals", 0, 32'(ill), 32'd0);
        end
        $display("win game: winner0=%0d winner1=%0d", d_win[0], d_win[1]);

        // 5: full draw
        pulse_new_game();
        for (int m = 0; m < 9; m++) play(draw_r[m], draw_c[m]);
        cmp("draw_winner", 0, 32'(d_win[0]), 32'd3);
        cmp("draw_game_over", 0, 32'(d_go[0]), 32'd1);
        cmp("draw_count", 0, 32'(d_cnt[0]), 32'd9);
        $display("draw game: winner0=%0d count0=%0d", d_win[0], d_cnt[0]);

        // 6a: new_game during a three-cycle select pulse
        pulse_new_game();
        play(2, 2);
        pulse_move(0, 0);
        step();
        cmp("ng_sel_before", 1, 32'(d_select[1]), 32'd1);
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        cmp("ng_sel_dropped", 1, 32'(d_select[1]), 32'd0);
        cmp("ng_cell_clear", 1, 32'(d_clr[1]), 32'd1);
        cmp("ng_board", 1, 32'(d_board[1]), 32'h0);
        cmp("ng_player", 1, 32'(d_player[1]), 32'd1);
        step();
        cmp("ng_cell_clear_once", 1, 32'(d_clr[1]), 32'd0);
        wait_cycles(3);
        $display("new_game mid-commit: board1=%0h", d_board[1]);

        // 6b: reset mid-game
        play(2, 2);
        play(0, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        cmp("rst_board", 0, 32'(d_board[0]), 32'h0);
        cmp("rst_count", 0, 32'(d_cnt[0]), 32'd0);
        cmp("rst_no_clear", 0, 32'(d_clr[0]), 32'd0);
        step();
        $display("reset mid-game: board0=%0h", d_board[0]);

        // 7: randomized play, including strobes in busy states
        for (int k = 0; k < 3000; k++) begin
            int r = int'($urandom_range(0, 7));
            int c = int'($urandom_range(0, 7));
            move_req = ($urandom_range(0, 2) == 0);
            row_in   = (r < 7) ? 2'(r % 3) : 2'd3;
            col_in   = (c < 7) ? 2'(c % 3) : 2'd3;
            new_game = ($urandom_range(0, 149) == 0);
            reset    = ($urandom_range(0, 499) != 0);
            step();
            if (k % 500 == 499)
                $display("random cycle %0d: board0=%05h board1=%05h", k + 1, d_board[0], d_board[1]);
        end
        move_req = 1'b0; new_game = 1'b0; reset = 1'b1;
        wait_cycles(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ttt_move_controller.md
Name: ttt_move_controller

Overview:
- Sequences a 3x3 tic-tac-toe game on top of cell_module, which drives the 16x16 red LED array.
- Accepts raw move requests (row/col plus a one-cycle strobe), rejects illegal moves and alternates players.
- Drives cell_module's player/select/row/col pins and keeps an internal board mirror.
- Detects win and draw from the mirror, then halts play until a new game is requested.

Parameters:
FIRST_PLAYER, 0, player that moves first after reset or new_game (0 or 1)
SELECT_CYCLES, 1, width in clocks of the select pulse issued to cell_module (1..4)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-low; reset asserted when reset==0 at posedge clock
move_req  input  1  one-cycle strobe: user requests a move at row_in/col_in
row_in  input  2  requested row, 0..2 valid, 3 illegal
col_in  input  2  requested column, 0..2 valid, 3 illegal
new_game  input  1  one-cycle strobe: clear board and restart
player  output  1  current player to cell_module (0 or 1)
select  output  1  commit strobe to cell_module
row  output  2  committed row to cell_module
col  output  2  committed column to cell_module
cell_clear  output  1  one-cycle clear to cell_module on new_game
board  output  18  board mirror, cell k=row*3+col at bits [2k+1:2k]; 00 empty, 01 player0, 10 player1
move_count  output  4  moves committed this game, 0..9
illegal_move  output  1  one-cycle pulse on a rejected request
game_over  output  1  high while in DONE
winner  output  2  00 none, 01 player0, 10 player1, 11 draw

Behaviour:
- Reset (reset==0 at posedge):
  - player=FIRST_PLAYER, select=0, row=0, col=0, cell_clear=0, board=0, move_count=0, illegal_move=0, game_over=0, winner=00.
  - State PLAY.
  - Reset mid-operation aborts any select pulse in progress.
- States: PLAY, CHECK, COMMIT, EVAL, DONE.
- PLAY: move_req=1 at edge N latches row_in/col_in into row/col; state CHECK at N+1.
- CHECK (one cycle), evaluated on the latched values:
  - Illegal if row==3, col==3, or the target cell is non-zero.
  - Illegal: illegal_move=1 for exactly the cycle after CHECK, board unchanged, return to PLAY.
  - Legal: go to COMMIT.
- COMMIT:
  - select=1 for SELECT_CYCLES consecutive cycles, starting the cycle after CHECK.
  - player, row and col are held stable throughout.
  - Board cell is written with player+1 and move_count increments on the first COMMIT cycle.
  - After the last select cycle, select=0 and state EVAL.
- EVAL (one cycle), checks the updated board:
  - Any of the 8 lines (3 rows, 3 columns, 2 diagonals) holding three equal non-zero codes: winner=that code, game_over=1, go to DONE.
  - Otherwise, if move_count==9: winner=11, game_over=1, go to DONE.
  - Otherwise: toggle player, go to PLAY.
- Latency, legal move with SELECT_CYCLES=1:
  - move_req at edge N, select high during cycle N+2.
  - player toggles and PLAY is re-entered at N+4; earliest accepted next move_req is at edge N+4.
- Ignored strobes:
  - move_req in CHECK, COMMIT, EVAL or DONE is dropped; it is not queued.
  - move_req and new_game at the same edge: new_game wins and move_req is dropped.
- new_game, in any state:
  - Next cycle: board=0, move_count=0, winner=00, game_over=0, select=0, player=FIRST_PLAYER, state PLAY.
  - cell_clear=1 for exactly that one cycle.
- DONE: outputs hold until new_game or reset.
- Win takes priority over draw when the ninth move completes a line.
- select never asserts for an illegal move or outside COMMIT.
- board never has a cell overwritten once non-zero.

Test Plan:
1. Reset held low 2 cycles then released -> all outputs at reset values, player=0, board=18'h0.
2. Move (1,1) with SELECT_CYCLES=1:
   - move_req at edge N -> select=1 only in cycle N+2 with row=1, col=1, player=0.
   - board bits[9:8]=01, move_count=1, player=1 at N+4.
3. Illegal requests -> illegal_move pulses once for each; board, move_count and player unchanged; select never asserts.
   - Repeat (1,1) after scenario 2.
   - Request (3,0).
4. Player0 win, moves (0,0),(1,0),(0,1),(1,1),(0,2):
   - After the fifth EVAL: winner=01, game_over=1, move_count=5.
   - A further move_req produces no select and no illegal_move.
5. Full draw sequence (0,0),(0,1),(0,2),(1,1),(1,0),(1,2),(2,1),(2,0),(2,2) -> winner=11, game_over=1, move_count=9.
6. Interrupts:
   - new_game asserted during a COMMIT with SELECT_CYCLES=3 -> select drops next cycle, cell_clear pulses once, board=0, player=FIRST_PLAYER.
   - reset=0 mid-game -> same clear without a cell_clear pulse.
